// File: rtl/wb_mem_slave.sv
// Wishbone classic slave backed by a 2^ADDR_WIDTH x 32-bit memory.
// Fixed latency of WAIT_STATES+2 cycles from acceptance to a one-cycle ack/err.
module wb_mem_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        decode_r, decode_s;
    logic        bad_r, bad_s;
    logic [31:0] addr_r, addr_s;
    logic        we_r, we_s;
    logic [31:0] data_r, data_s;
    logic [3:0]  sel_r, sel_s;
    logic        ack_r, ack_s;
    logic        err_r, err_s;
    logic [31:0] rdata_r, rdata_s;
    logic        mem_we_s;
    logic        addr_bad_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;

    assign word_idx_s = addr_r[ADDR_WIDTH+1:2];
    // Misaligned or beyond the memory depth; evaluated once in the decode cycle.
    assign addr_bad_s = (addr_r[1:0] != 2'b00) || ((addr_r >> (ADDR_WIDTH + 2)) != 32'd0);

    // Next-state, request capture and response generation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        decode_s = decode_r;
        bad_s    = bad_r;
        addr_s   = addr_r;
        we_s     = we_r;
        data_s   = data_r;
        sel_s    = sel_r;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        rdata_s  = 32'd0;
        mem_we_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    addr_s   = i_wb_addr;
                    we_s     = i_wb_we;
                    data_s   = i_wb_data;
                    sel_s    = i_wb_sel;
                    cnt_s    = WAIT_LOAD;
                    decode_s = 1'b1;
                    state_s  = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    decode_s = 1'b0;
                    state_s  = IDLE;
                end else if (decode_r) begin
                    decode_s = 1'b0;
                    bad_s    = addr_bad_s;
                end else if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    state_s = RESP;
                    if (bad_r) begin
                        err_s = 1'b1;
                    end else begin
                        ack_s = 1'b1;
                        if (we_r) begin
                            mem_we_s = 1'b1;
                        end else begin
                            rdata_s = mem[word_idx_s];
                        end
                    end
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control and output registers; memory is deliberately outside the reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            decode_r <= 1'b0;
            bad_r    <= 1'b0;
            addr_r   <= 32'd0;
            we_r     <= 1'b0;
            data_r   <= 32'd0;
            sel_r    <= 4'd0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            decode_r <= decode_s;
            bad_r    <= bad_s;
            addr_r   <= addr_s;
            we_r     <= we_s;
            data_r   <= data_s;
            sel_r    <= sel_s;
            ack_r    <= ack_s;
            err_r    <= err_s;
            rdata_r  <= rdata_s;
        end
    end

    // Byte-lane write on the edge that raises ack.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[word_idx_s] <= merge_bytes(mem[word_idx_s], data_r, sel_r);
        end
    end

    assign o_wb_data = rdata_r;
    assign o_wb_ack  = ack_r;
    assign o_wb_err  = err_r;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomized bench for wb_mem_slave: a word-array model predicts every
// response cycle, data value and memory update.
module tb_wb_mem_slave;

    localparam int AW = 10;
    localparam int WS = 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  sel   = 4'd0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] model [0:15];

    wb_mem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_addr (addr),
        .i_wb_data (wdata),
        .i_wb_sel  (sel),
        .o_wb_data (rdata),
        .o_wb_ack  (ack),
        .o_wb_err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
    endfunction

    task automatic chk_quiet(input string tag);
        chk_eq({tag, "_ack"}, {31'd0, ack}, 32'd0);
        chk_eq({tag, "_err"}, {31'd0, err}, 32'd0);
        chk_eq({tag, "_dat"}, rdata, 32'd0);
    endtask

    // One complete transaction; called #1 after a rising edge with the slave idle.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit short_stb, input string tag);
        bit bad;
        int idx;
        logic [31:0] exp_d;
        bad = is_bad(a);
        idx = (a / 4) % 16;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        if (short_stb) begin
            stb = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; sel = $urandom;
        end
        for (int n = 1; n <= WS + 3; n++) begin
            @(posedge clk); #1;
            if (n == WS + 2) begin
                exp_d = (bad || w) ? 32'd0 : model[idx];
                chk_eq({tag, "_ack"}, {31'd0, ack}, {31'd0, !bad});
                chk_eq({tag, "_err"}, {31'd0, err}, {31'd0, bad});
                chk_eq({tag, "_dat"}, rdata, exp_d);
                if (!bad && w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end else begin
                chk_quiet({tag, "_idle"});
            end
        end
        stb = 1'b0;
        if (short_stb) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk_quiet({tag, "_noreacc"});
            end
        end
        cyc = 1'b0;
    endtask

    task automatic abort_write(input logic [31:0] a, input logic [31:0] d, input int drop_after);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (drop_after) @(posedge clk);
        if (drop_after > 0) #1;
        cyc = 1'b0;
        repeat (WS + 4) begin
            @(posedge clk); #1;
            chk_quiet("abort");
        end
    endtask

    initial begin
        logic [31:0] a;
        int word;
        #1;
        chk_quiet("reset0");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill the pool so every later read has a known expectation.
        for (int i = 0; i < 16; i++) access(1'b1, i * 4, $urandom, 4'hF, 1'b0, "fill");

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10");
        access(1'b0, 32'h10, 32'd0, 4'hF, 1'b0, "rd10");
        access(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, "wr20");
        access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "lane20");
        access(1'b0, 32'h20, 32'd0, 4'hF, 1'b0, "rdlane");
        access(1'b1, 32'h20, 32'h55555555, 4'b0000, 1'b0, "sel0");
        access(1'b0, 32'h20, 32'd0, 4'hF, 1'b0, "rdsel0");
        access(1'b0, 32'h10, 32'd0, 4'hF, 1'b1, "short10");

        abort_write(32'h30, 32'hCAFEF00D, 0);
        abort_write(32'h30, 32'hCAFEF00D, WS);
        access(1'b0, 32'h30, 32'd0, 4'hF, 1'b0, "rd30");

        access(1'b1, 32'h12, 32'h12121212, 4'hF, 1'b0, "bad12");
        access(1'b0, 32'h12, 32'd0, 4'hF, 1'b0, "badrd12");
        access(1'b1, 32'd1 << (AW + 2), 32'h0BAD0BAD, 4'hF, 1'b0, "badhi");
        access(1'b0, 32'h0, 32'd0, 4'hF, 1'b0, "rd0");
        access(1'b0, 32'h10, 32'd0, 4'hF, 1'b0, "rd10b");

        // Reset while the write is still waiting.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h01020304; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        reset = 1'b0;
        #1 chk_quiet("rstwait");
        @(posedge clk); #1;
        chk_quiet("rsthold");
        reset = 1'b1;
        cyc = 1'b0;
        access(1'b0, 32'h10, 32'd0, 4'hF, 1'b0, "rstrd10");

        // Reset during the ack cycle must clear the outputs immediately.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h20;
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (WS + 2) @(posedge clk);
        #1;
        chk_eq("rstack_pre", {31'd0, ack}, 32'd1);
        chk_eq("rstack_dat", rdata, model[8]);
        reset = 1'b0;
        #1 chk_quiet("rstack");
        #2 reset = 1'b1;
        cyc = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 80; i++) begin
            word = $urandom_range(15, 0);
            a = word * 4;
            case ($urandom_range(7, 0))
                0: a = a + $urandom_range(3, 1);
                1: a = a | (32'd1 << (AW + 2 + $urandom_range(19, 0)));
                default: a = a;
            endcase
            access($urandom, a, $urandom, $urandom, $urandom, "rand");
        end

        for (int i = 0; i < 16; i++) access(1'b0, i * 4, 32'd0, 4'hF, 1'b0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
